pixel_sequencer: RTL and testbench
==================================

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8: width of the digital ramp bus.
REQ-002 SHALL have parameter C_ERASE, default 5: ERASE phase length in clk cycles.
REQ-003 SHALL have parameter C_EXPOSE, default 255: EXPOSE phase length in clk cycles.
REQ-004 SHALL have parameter C_CONVERT, default 255: CONVERT phase length in clk cycles.
REQ-005 SHALL have parameter C_READ, default 5: READ phase length in clk cycles.
REQ-006 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  request one frame, sampled in IDLE.
REQ-009 SHALL have port continuous  input  1  free-run frames back-to-back.
REQ-010 SHALL have port abort  input  1  synchronous abort to IDLE.
REQ-011 SHALL have ports power_enable, write_enable, counter_reset, erase, expose, convert, read  output  1 each  pixel array controls.
REQ-012 SHALL have port ramp  output  BIT_DEPTH  digital ramp value, paired with the analog ramp.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle end-of-frame pulse.

Function
REQ-015 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT and READ, with one clock domain throughout.
REQ-016 SHALL register all outputs and decode them from the state register only (Moore): no combinational path from inputs to outputs.
REQ-017 SHALL drive the following outputs per state:
- IDLE: all controls 0.
- ERASE: erase=1, counter_reset=1.
- EXPOSE: expose=1, power_enable=1, write_enable=1.
- CONVERT: convert=1, power_enable=1, write_enable=1.
- READ: read=1, power_enable=1.
REQ-018 SHALL move IDLE->ERASE on a clk edge with start=1 and abort=0, and SHALL ignore start while busy.
REQ-019 SHALL hold each phase for exactly its C_* cycles; ERASE->EXPOSE->CONVERT->READ with no gap cycles.
REQ-020 SHALL treat a C_* value of 0 as 1.
REQ-021 SHALL, at READ exit, go to IDLE if continuous=0 and to ERASE if continuous=1; done=1 for that one following cycle in both cases.
REQ-022 SHALL hold ramp at 0 outside CONVERT; it is 0 in the first CONVERT cycle and increments by 1 per cycle.
REQ-023 SHALL saturate ramp at all-ones and never wrap when C_CONVERT > 2^BIT_DEPTH.
REQ-024 SHALL, on abort=1 in any non-IDLE state, enter IDLE on the next edge with no done pulse; abort has priority over start and over continuous.
REQ-025 SHALL use one phase counter, cleared on every state change; busy = (state != IDLE).

Reset
REQ-026 SHALL, while reset=0, asynchronously force state=IDLE, all controls=0, ramp=0, busy=0, done=0 and the phase counter=0.
REQ-027 SHALL, on reset assertion mid-frame, abandon the frame and emit no done; after reset release it stays IDLE until start.

Configuration
REQ-028 SHALL, with macro PIXEL_SEQUENCER_FRAME_COUNT_EN defined, add output frame_count (16 bits, reset 0) that increments by 1 on each done pulse, wraps FFFF->0 and is not cleared by abort.
REQ-029 SHALL, without PIXEL_SEQUENCER_FRAME_COUNT_EN, omit the frame_count port and its logic entirely.

Verification (C_ERASE=2, C_EXPOSE=3, C_CONVERT=4, C_READ=2, BIT_DEPTH=8 unless stated)
REQ-030 SHALL cover single frame: start pulse at edge 0 -> erase cycles 1-2, expose 3-5, convert 6-9 with ramp 0,1,2,3, read 10-11, done=1 and IDLE at cycle 12, busy=0 from cycle 12.
REQ-031 SHALL cover continuous: continuous=1 with start at edge 0 -> second ERASE begins at cycle 12 with done=1 the same cycle, no IDLE cycle between frames.
REQ-032 SHALL cover abort: abort=1 at cycle 7 (CONVERT) -> IDLE at cycle 8, ramp=0, no done; start at cycle 8 -> ERASE at cycle 9.
REQ-033 SHALL cover saturation: BIT_DEPTH=2, C_CONVERT=6 -> ramp sequence 0,1,2,3,3,3.
REQ-034 SHALL cover reset mid-EXPOSE: reset=0 at cycle 4 -> all outputs 0 immediately without waiting for an edge; after release, stays IDLE while start=0.
REQ-035 SHALL cover counter (macro defined): three frames -> frame_count=3; one aborted frame leaves it unchanged.

Source files
------------

// File: rtl/pixel_sequencer.sv
// pixel_sequencer
//   Frame sequencer for a pixel array: IDLE -> ERASE -> EXPOSE -> CONVERT ->
//   READ, each phase held for a parameterised number of clk cycles (0 acts
//   as 1). During CONVERT a digital ramp counts up from 0 and saturates at
//   all-ones. Every output is a flop loaded from the decoded next state, so
//   outputs change only on clk edges (or on reset) and there is no
//   combinational path from any input to any output.
//
//   Optional feature: define PIXEL_SEQUENCER_FRAME_COUNT_EN to add a 16-bit
//   frame_count output. It counts done pulses, wraps, and is not cleared by
//   abort.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   start          in   request one frame (only honoured in IDLE)
//   continuous     in   sampled at READ exit: 1 = start next frame at once
//   abort          in   synchronous return to IDLE, no done pulse
//   power_enable, write_enable, counter_reset,
//   erase, expose, convert, read
//                  out  pixel array controls
//   ramp           out  [BIT_DEPTH-1:0] digital ramp value
//   busy           out  high whenever the state is not IDLE
//   done           out  one-cycle pulse in the cycle after READ ends
//   frame_count    out  [15:0] completed frames (PIXEL_SEQUENCER_FRAME_COUNT_EN)
//   o_dbg_state    out  [2:0] current FSM state, for observation only
//
//   Control protocol: start/continuous/abort are level inputs sampled on
//   every rising edge; there is no handshake. abort wins over start and
//   continuous; start is ignored while busy.
module pixel_sequencer #(
  parameter int BIT_DEPTH = 8,
  parameter int C_ERASE   = 5,
  parameter int C_EXPOSE  = 255,
  parameter int C_CONVERT = 255,
  parameter int C_READ    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  output logic                 power_enable,
  output logic                 write_enable,
  output logic                 counter_reset,
  output logic                 erase,
  output logic                 expose,
  output logic                 convert,
  output logic                 read,
  output logic [BIT_DEPTH-1:0] ramp,
  output logic                 busy,
  output logic                 done,
`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
  output logic [15:0]          frame_count,
`endif
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4
  } state_t;

  // A zero-length phase would have no cycle to live in, so it runs for one.
  localparam int L_ERASE   = (C_ERASE   < 1) ? 1 : C_ERASE;
  localparam int L_EXPOSE  = (C_EXPOSE  < 1) ? 1 : C_EXPOSE;
  localparam int L_CONVERT = (C_CONVERT < 1) ? 1 : C_CONVERT;
  localparam int L_READ    = (C_READ    < 1) ? 1 : C_READ;
  localparam int L_MAX_A   = (L_ERASE  > L_EXPOSE) ? L_ERASE  : L_EXPOSE;
  localparam int L_MAX_B   = (L_CONVERT > L_READ)  ? L_CONVERT : L_READ;
  localparam int L_MAX     = (L_MAX_A  > L_MAX_B)  ? L_MAX_A  : L_MAX_B;
  // The counter only ever holds 0 .. L_MAX-1.
  localparam int CNT_W     = (L_MAX < 2) ? 1 : $clog2(L_MAX);

  localparam logic [CNT_W-1:0] LAST_ERASE   = CNT_W'(L_ERASE   - 1);
  localparam logic [CNT_W-1:0] LAST_EXPOSE  = CNT_W'(L_EXPOSE  - 1);
  localparam logic [CNT_W-1:0] LAST_CONVERT = CNT_W'(L_CONVERT - 1);
  localparam logic [CNT_W-1:0] LAST_READ    = CNT_W'(L_READ    - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_DEPTH-1:0] r_ramp;
  logic                 r_power_enable, r_write_enable, r_counter_reset;
  logic                 r_erase, r_expose, r_convert, r_read;
  logic                 r_busy, r_done;

  state_t               w_next;
  logic                 w_last;
  logic                 w_frame_end;
  logic [BIT_DEPTH-1:0] w_ramp_next;

  // Final cycle of the current phase.
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_ERASE:   w_last = (r_cnt == LAST_ERASE);
      S_EXPOSE:  w_last = (r_cnt == LAST_EXPOSE);
      S_CONVERT: w_last = (r_cnt == LAST_CONVERT);
      S_READ:    w_last = (r_cnt == LAST_READ);
      default:   w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_next = S_ERASE;
      end
      S_ERASE: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_EXPOSE;
      end
      S_EXPOSE: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_CONVERT;
      end
      S_CONVERT: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_READ;
      end
      S_READ: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = continuous ? S_ERASE : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A frame completes only by leaving READ normally; abort suppresses done.
  assign w_frame_end = (r_state == S_READ) && w_last && !abort;

  // Ramp restarts at 0 on entry to CONVERT and sticks at all-ones.
  always_comb begin
    w_ramp_next = '0;
    if ((r_state == S_CONVERT) && (w_next == S_CONVERT)) begin
      w_ramp_next = (&r_ramp) ? r_ramp : r_ramp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_ramp          <= '0;
      r_power_enable  <= 1'b0;
      r_write_enable  <= 1'b0;
      r_counter_reset <= 1'b0;
      r_erase         <= 1'b0;
      r_expose        <= 1'b0;
      r_convert       <= 1'b0;
      r_read          <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_cnt           <= ((w_next != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + 1'b1;
      r_ramp          <= w_ramp_next;
      r_power_enable  <= (w_next == S_EXPOSE) || (w_next == S_CONVERT) || (w_next == S_READ);
      r_write_enable  <= (w_next == S_EXPOSE) || (w_next == S_CONVERT);
      r_counter_reset <= (w_next == S_ERASE);
      r_erase         <= (w_next == S_ERASE);
      r_expose        <= (w_next == S_EXPOSE);
      r_convert       <= (w_next == S_CONVERT);
      r_read          <= (w_next == S_READ);
      r_busy          <= (w_next != S_IDLE);
      r_done          <= w_frame_end;
    end
  end

`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  // Steps on the same edge that raises done, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_frame_count <= '0;
    else if (w_frame_end) r_frame_count <= r_frame_count + 16'd1;
  end

  assign frame_count = r_frame_count;
`endif

  assign power_enable  = r_power_enable;
  assign write_enable  = r_write_enable;
  assign counter_reset = r_counter_reset;
  assign erase         = r_erase;
  assign expose        = r_expose;
  assign convert       = r_convert;
  assign read          = r_read;
  assign ramp          = r_ramp;
  assign busy          = r_busy;
  assign done          = r_done;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pixel_sequencer.sv
module tb_pixel_sequencer;

  localparam int BD = 8;
  localparam int LE = 2;
  localparam int LX = 3;
  localparam int LC = 4;
  localparam int LR = 2;
  localparam int VW = 9 + BD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // main instance (verification timing)
  logic          start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic          power_enable, write_enable, counter_reset, erase, expose, convert, read;
  logic [BD-1:0] ramp;
  logic          busy, done;
  logic [2:0]    dbg_state;
`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
  logic [15:0]   frame_count;
`endif

  // second instance: 2-bit ramp saturation and zero-length phases
  logic          s2_start = 1'b0;
  logic          s2_pe, s2_we, s2_cr, s2_erase, s2_expose, s2_convert, s2_read;
  logic [1:0]    s2_ramp;
  logic          s2_busy, s2_done;
  logic [2:0]    s2_dbg_state;
`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
  logic [15:0]   s2_frame_count;
`endif

  pixel_sequencer #(
    .BIT_DEPTH(BD), .C_ERASE(LE), .C_EXPOSE(LX), .C_CONVERT(LC), .C_READ(LR)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .power_enable(power_enable), .write_enable(write_enable), .counter_reset(counter_reset),
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .ramp(ramp), .busy(busy), .done(done),
`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
    .frame_count(frame_count),
`endif
    .o_dbg_state(dbg_state)
  );

  pixel_sequencer #(
    .BIT_DEPTH(2), .C_ERASE(0), .C_EXPOSE(1), .C_CONVERT(6), .C_READ(0)
  ) dut_sat (
    .clk(clk), .reset(rst_n), .start(s2_start), .continuous(1'b0), .abort(1'b0),
    .power_enable(s2_pe), .write_enable(s2_we), .counter_reset(s2_cr),
    .erase(s2_erase), .expose(s2_expose), .convert(s2_convert), .read(s2_read),
    .ramp(s2_ramp), .busy(s2_busy), .done(s2_done),
`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
    .frame_count(s2_frame_count),
`endif
    .o_dbg_state(s2_dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int             checks = 0;
  int             errors = 0;
  logic [VW-1:0]  exp_q[$];     // remaining per-cycle outputs of the current frame
  logic [VW-1:0]  exp_vec;      // expected outputs for the cycle just entered
  logic           m_busy = 1'b0;
  logic [15:0]    m_fc = '0;

  // packed as {pe, we, cr, erase, expose, convert, read, busy, done, ramp}
  function automatic logic [VW-1:0] vec(input logic pe, we, cr, er, ex, cv, rd, bz, dn,
                                        input logic [BD-1:0] rp);
    return {pe, we, cr, er, ex, cv, rd, bz, dn, rp};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {power_enable, write_enable, counter_reset, erase, expose, convert, read,
            busy, done, ramp};
  endfunction

  // One frame as a list of cycles, straight from the per-phase output table.
  task automatic load_frame();
    exp_q.delete();
    for (int i = 0; i < LE; i++) exp_q.push_back(vec(0, 0, 1, 1, 0, 0, 0, 1, 0, '0));
    for (int i = 0; i < LX; i++) exp_q.push_back(vec(1, 1, 0, 0, 1, 0, 0, 1, 0, '0));
    for (int i = 0; i < LC; i++)
      exp_q.push_back(vec(1, 1, 0, 0, 0, 1, 0, 1, 0, BD'((i > 255) ? 255 : i)));
    for (int i = 0; i < LR; i++) exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 1, 1, 0, '0));
  endtask

  // Drive inputs for one edge, predict the cycle after it, stop just past the edge.
  task automatic step(input logic s, input logic c, input logic a);
    @(negedge clk);
    start = s; continuous = c; abort = a;
    if (!m_busy) begin
      if (s && !a) begin
        load_frame();
        exp_vec = exp_q.pop_front();
        m_busy = 1'b1;
      end else begin
        exp_vec = '0;
      end
    end else if (a) begin
      exp_q.delete();
      exp_vec = '0;
      m_busy = 1'b0;
    end else if (exp_q.size() > 0) begin
      exp_vec = exp_q.pop_front();
    end else if (c) begin
      load_frame();
      exp_vec = exp_q.pop_front();
      exp_vec[BD] = 1'b1;
    end else begin
      exp_vec = '0;
      exp_vec[BD] = 1'b1;
      m_busy = 1'b0;
    end
    if (exp_vec[BD]) m_fc = m_fc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", dut_vec(), {VW{1'b0}});
    end
    checks++;
    if ({s2_busy, s2_done, s2_ramp, s2_erase, s2_convert} !== '0) begin
      errors++;
      $display("FAIL reset_sat_outputs: got %b expected 0",
               {s2_busy, s2_done, s2_ramp, s2_erase, s2_convert});
    end
`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_count: got %0d expected 0", frame_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_single_frame();
    for (int k = 1; k <= 13; k++) begin
      step(k == 1, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL single_frame cycle %0d: got %h expected %h", k, dut_vec(), exp_vec);
      end
      if (k >= 6 && k <= 9) begin
        checks++;
        if (ramp !== BD'(k - 6)) begin
          errors++;
          $display("FAIL single_ramp cycle %0d: got %0d expected %0d", k, ramp, k - 6);
        end
      end
      if (k == 12) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL single_done cycle 12: got done=%b busy=%b expected done=1 busy=0",
                   done, busy);
        end
      end
    end
  endtask

  task automatic test_continuous();
    int idle_cycles = 0;
    for (int k = 1; k <= 12; k++) begin
      step(k == 1, 1, 0);
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL continuous cycle %0d: got %h expected %h", k, dut_vec(), exp_vec);
      end
      if (!busy) idle_cycles++;
    end
    checks++;
    if (erase !== 1'b1 || done !== 1'b1 || idle_cycles != 0) begin
      errors++;
      $display("FAIL continuous_rollover: got erase=%b done=%b idle=%0d expected 1 1 0",
               erase, done, idle_cycles);
    end
    step(0, 0, 1);
    checks++;
    if (dut_vec() !== exp_vec) begin
      errors++;
      $display("FAIL continuous_abort: got %h expected %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_abort();
    for (int k = 1; k <= 7; k++) begin
      step(k == 1, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL abort_pre cycle %0d: got %h expected %h", k, dut_vec(), exp_vec);
      end
    end
    step(1, 1, 1);  // abort beats both start and continuous
    checks++;
    if (dut_vec() !== '0 || dut_vec() !== exp_vec) begin
      errors++;
      $display("FAIL abort_idle cycle 8: got %h expected 0", dut_vec());
    end
    step(1, 0, 0);
    checks++;
    if (erase !== 1'b1 || dut_vec() !== exp_vec) begin
      errors++;
      $display("FAIL abort_restart cycle 9: got %h expected %h", dut_vec(), exp_vec);
    end
    step(0, 0, 1);
    checks++;
    if (dut_vec() !== exp_vec) begin
      errors++;
      $display("FAIL abort_cleanup: got %h expected %h", dut_vec(), exp_vec);
    end
  endtask

  task automatic test_saturation();
    int ramps[$];
    int exp_ramp[6] = '{0, 1, 2, 3, 3, 3};
    int busy_n = 0, er_n = 0, ex_n = 0, rd_n = 0, done_at = -1;
    int got;
    @(negedge clk);
    s2_start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      s2_start = 1'b0;
      if (s2_busy) busy_n++;
      if (s2_erase) er_n++;
      if (s2_expose) ex_n++;
      if (s2_read) rd_n++;
      if (s2_convert) ramps.push_back(int'(s2_ramp));
      if (s2_done && done_at < 0) done_at = k;
    end
    checks++;
    if (ramps.size() != 6) begin
      errors++;
      $display("FAIL sat_convert_len: got %0d expected 6", ramps.size());
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < ramps.size()) ? ramps[i] : -1;
      checks++;
      if (got != exp_ramp[i]) begin
        errors++;
        $display("FAIL sat_ramp[%0d]: got %0d expected %0d", i, got, exp_ramp[i]);
      end
    end
    checks++;
    if (er_n != 1 || ex_n != 1 || rd_n != 1) begin
      errors++;
      $display("FAIL sat_zero_len: got erase=%0d expose=%0d read=%0d expected 1 1 1",
               er_n, ex_n, rd_n);
    end
    checks++;
    if (busy_n != 9 || done_at != 10) begin
      errors++;
      $display("FAIL sat_frame: got busy=%0d done_at=%0d expected 9 10", busy_n, done_at);
    end
  endtask

  task automatic test_reset_mid_expose();
    for (int k = 1; k <= 4; k++) begin
      step(k == 1, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL rst_pre cycle %0d: got %h expected %h", k, dut_vec(), exp_vec);
      end
    end
    checks++;
    if (expose !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_expose: got %b expected 1", expose);
    end
    #2;                      // mid-cycle, no clock edge nearby
    rst_n = 1'b0;
    exp_q.delete();
    m_busy = 1'b0;
    m_fc = '0;
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL rst_async: got %h expected 0", dut_vec());
    end
`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_frame_count: got %0d expected 0", frame_count);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0);
      checks++;
      if (dut_vec() !== '0 || dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL rst_stays_idle %0d: got %h expected 0", k, dut_vec());
      end
    end
  endtask

`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
  task automatic test_frame_count();
    for (int f = 0; f < 3; f++) begin
      for (int k = 1; k <= 12; k++) step(k == 1, 0, 0);
    end
    step(0, 0, 0);
    checks++;
    if (frame_count !== 16'd3 || frame_count !== m_fc) begin
      errors++;
      $display("FAIL frame_count_three: got %0d expected 3", frame_count);
    end
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    checks++;
    if (frame_count !== 16'd3) begin
      errors++;
      $display("FAIL frame_count_abort: got %0d expected 3", frame_count);
    end
  endtask
`endif

  task automatic test_random();
    logic s, c, a;
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 3) == 0);
      c = $urandom_range(0, 1) != 0;
      a = ($urandom_range(0, 24) == 0);
      step(s, c, a);
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL random step %0d (s=%b c=%b a=%b): got %h expected %h",
                 n, s, c, a, dut_vec(), exp_vec);
      end
`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
      checks++;
      if (frame_count !== m_fc) begin
        errors++;
        $display("FAIL random_frame_count step %0d: got %0d expected %0d", n, frame_count, m_fc);
      end
`endif
    end
    step(0, 0, 1);
    step(0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec) begin
      errors++;
      $display("FAIL random_end: got %h expected %h", dut_vec(), exp_vec);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_abort();
    test_saturation();
    test_reset_mid_expose();
`ifdef PIXEL_SEQUENCER_FRAME_COUNT_EN
    test_frame_count();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish within 200000 time units");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
